// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, fetch FSM encoding and helpers for the fetch front end
//
// Contents:
//   RESET_PC_DEF  default reset PC (32'h0000_3000)
//   XLEN          instruction / address width (32)
//   fetch_state_e fetch FSM states BOOT / RUN / HALT
//   misaligned()  true when an address is not word aligned
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int          XLEN         = 32;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    function automatic logic misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_skid_buf.sv
// rtl/ifu_skid_buf.sv - two-entry output/skid buffer between fetch responses and decode
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   s_tvalid, s_tdata     incoming fetch response {pc, instr}; always accepted
//   m_tvalid, m_tready    output handshake towards decode
//   m_tdata               output register contents {pc, instr}
//   occ                   number of valid entries (0..2)
//
// The upstream issue logic guarantees a response never arrives while both
// entries are full and no dequeue happens, so there is no s_tready.
module ifu_skid_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_tvalid,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata,
    output logic [1:0]   occ
);

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q,  out_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] skid_data_q,  skid_data_d;
    logic         deq;

    assign deq = out_valid_q & m_tready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        // Dequeue first: the older skid entry refills the output register.
        if (deq) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        // A new word only bypasses into the output register when nothing older
        // remains ahead of it; otherwise it parks in the skid register.
        if (s_tvalid) begin
            if (!out_valid_q || (deq && !skid_valid_q)) begin
                out_valid_d = 1'b1;
                out_data_d  = s_tdata;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_tdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign m_tvalid = out_valid_q;
    assign m_tdata  = out_data_q;
    assign occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - PC register, fetch FSM and instruction-memory front end feeding decode
//
// Optional feature macro: IFU_RANGE_CHECK_EN (also fault on npc outside the
// instruction memory window; when undefined such addresses wrap via im_addr).
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   npc              next PC from NPC, committed when a fetch issues
//   pc               current PC, to NPC now_PC
//   im_addr          instruction memory word address
//   im_en            read strobe, high exactly on issue cycles
//   im_rdata         read data, valid the cycle after im_en
//   instr, instr_pc  instruction and its PC to decode
//   instr_valid      instr/instr_pc valid
//   instr_ready      decode accepts when valid & ready
//   fault            sticky fetch fault
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_DEPTH = 4096
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [XLEN-1:0]             npc,
    output logic [XLEN-1:0]             pc,
    output logic [$clog2(IM_DEPTH)-1:0] im_addr,
    output logic                        im_en,
    input  logic [XLEN-1:0]             im_rdata,
    output logic [XLEN-1:0]             instr,
    output logic [XLEN-1:0]             instr_pc,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic                        fault
);

    localparam int AW = $clog2(IM_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pending_q, pending_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            fault_q, fault_d;

    logic [1:0]      buf_occ;
    logic [2:0]      occ;
    logic            deq;
    logic            issue;
    logic            bad_npc;

    ifu_skid_buf #(.W(2*XLEN)) u_buf (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tvalid (pending_q),
        .s_tdata  ({pend_pc_q, im_rdata}),
        .m_tvalid (instr_valid),
        .m_tready (instr_ready),
        .m_tdata  ({instr_pc, instr}),
        .occ      (buf_occ)
    );

    // Count the in-flight word too, so an issue is only made when its
    // response is guaranteed a free buffer slot on arrival.
    assign occ   = {2'b00, pending_q} + {1'b0, buf_occ};
    assign deq   = instr_valid & instr_ready;
    assign issue = (state_q == ST_RUN) && ((occ - {2'b00, deq}) < 3'd2);

`ifdef IFU_RANGE_CHECK_EN
    localparam logic [32:0] IM_END = {1'b0, RESET_PC} + 33'(4 * IM_DEPTH);
    assign bad_npc = misaligned(npc) || (npc < RESET_PC) || ({1'b0, npc} >= IM_END);
`else
    assign bad_npc = misaligned(npc);
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        pend_pc_d = pend_pc_q;
        fault_d   = fault_q;

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase

        // The response for the previous issue is consumed this cycle.
        if (pending_q) begin
            pending_d = 1'b0;
        end

        // The word at pc_q is fetched even when npc is bad; only the PC
        // advance is refused, so the fault surfaces after that word.
        if (issue) begin
            pending_d = 1'b1;
            pend_pc_d = pc_q;
            if (bad_npc) begin
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else begin
                pc_d = npc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            pend_pc_q <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            pend_pc_q <= pend_pc_d;
            fault_q   <= fault_d;
        end
    end

    assign pc      = pc_q;
    assign im_en   = issue;
    assign im_addr = AW'((pc_q - RESET_PC) >> 2);
    assign fault   = fault_q;

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- PC register and instruction-fetch front end. Sits directly upstream of NPC.
- Holds the current PC and drives it to NPC as now_PC; commits NPC's npc when a fetch is issued.
- Drives a synchronous 1-cycle-latency instruction memory and presents fetched words to decode over a valid/ready handshake.
- Two-entry buffer (output register plus skid register) absorbs decode stalls without losing or duplicating instructions.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_DEPTH, 4096, instruction memory words; im_addr width is log2(IM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- npc  in  32  next PC from NPC
- pc  out  32  current PC (pc_q), to NPC now_PC
- im_addr  out  log2(IM_DEPTH)  word address = (pc_q - RESET_PC) >> 2
- im_en  out  1  read strobe; high for exactly the cycles a fetch issues
- im_rdata  in  32  read data, valid the cycle after im_en
- instr  out  32  instruction to decode
- instr_pc  out  32  PC of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  decode accepts when valid & ready
- fault  out  1  sticky fetch fault (misaligned npc)

Behaviour:
- Reset, asynchronous on reset_n low: pc_q=RESET_PC; state=BOOT; pending=0; instr_valid=0; skid_valid=0; instr=0; instr_pc=0; fault=0; im_en=0. Reset mid-operation discards in-flight data, and the late im_rdata is ignored.
- FSM:
  - BOOT: one idle cycle after reset release, then RUN.
  - RUN: fetch allowed.
  - HALT: entered on fault, exited only by reset.
- occ = pending + instr_valid + skid_valid, range 0..3 transiently, never more than 2 committed entries.
- deq = instr_valid & instr_ready.
- issue = (state==RUN) & (occ - deq < 2). im_en = issue.
- On issue:
  - pending<=1; pend_pc<=pc_q.
  - If npc[1:0]!=0: fault<=1, state<=HALT, pc_q unchanged.
  - Otherwise pc_q<=npc.
- Response, when pending was 1: the word is routed as follows.
  - If the output register is empty, or is being dequeued this cycle with skid empty, the word goes to instr/instr_pc.
  - Otherwise the word goes to the skid register.
  - pending clears unless a new issue fires the same cycle.
- Dequeue with skid_valid=1: skid moves to the output register the same edge; instr_valid stays 1. Order is strictly preserved.
- Simultaneous response and dequeue with skid full cannot occur, because the issue rule guarantees it.
- Output hold: while instr_valid & !instr_ready, instr and instr_pc are stable.
- Throughput: 1 instr/cycle with ready held high. First instr_valid appears 2 cycles after BOOT exits (issue cycle, then response cycle).
- HALT: no new issues. The already-pending word is still delivered, and buffered words drain normally.
- pc arithmetic is 32-bit unsigned wrap. im_addr is truncated to log2(IM_DEPTH) bits.

Optional Feature:
- IFU_RANGE_CHECK_EN defined: an issue is also a fault when npc < RESET_PC or npc >= RESET_PC + 4*IM_DEPTH. Same handling as misalignment: fault set, HALT, pc_q held.
- Not defined: out-of-range addresses wrap silently via im_addr truncation.

Decomposition:
- Shared package (cpu_pkg): RESET_PC default, instruction width 32, FSM state encoding (BOOT/RUN/HALT).
- One sub-module, ifu_skid_buf: the 2-entry output/skid buffer taking {pc,instr} in with valid, giving out valid/ready, plus an occupancy count.
- PC register and FSM stay in ifu_fetch.

Test Plan:
- Reset then ready=1, NPC fed pc+4, memory word i = 32'hA000_0000+i:
  - pc=3000 during BOOT.
  - instr_valid first rises 2 cycles after BOOT exits, with instr_pc=3000, instr=A0000000.
  - Then one instr per cycle: 3004/A0000001, 3008/A0000002.
- Drop instr_ready for 3 cycles mid-stream:
  - im_en stops after 2 entries are buffered, and instr stays stable.
  - On ready, 3008, 300C, 3010 appear in order with no gaps or duplicates.
- npc=32'h0000_3402 on an issue:
  - fault=1 the next cycle; pc holds; im_en stays 0.
  - Previously pending words still drain with ready=1.
- Branch: npc=32'h0000_3100 after pc=3004 issues. Next issued im_addr=0x40 and instr_pc=3100.
- Assert reset_n low while pending=1 and skid full:
  - All outputs return to reset values immediately, with pc=3000 and instr_valid=0.
  - The stale im_rdata is never presented.
- With IFU_RANGE_CHECK_EN: npc=32'h0000_7000 (IM_DEPTH=4096) gives fault=1. Without the macro, im_addr=0x000 and no fault.
